// File: rtl/if_pkg.sv
// Shared fetch/decode types: data width, queue depth, fetch entry.
// Imported by the IF/ID queue and the decode stage register.
package if_pkg;

  localparam int IF_DATA_W  = 32;
  localparam int IF_Q_DEPTH = 4;

  typedef struct packed {
    logic [IF_DATA_W-1:0] pc;
    logic [IF_DATA_W-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/if_queue_ptr.sv
// Modulo-DEPTH pointer register: async reset, sync clear, increment.
// Ports: clk, rst, clr (sync clear), inc (advance), ptr (current value).
module if_queue_ptr #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  // DEPTH is a power of two, so natural rollover is modulo DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (clr)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + PTR_W'(1);
  end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling FIFO: buffers {pc, instr} pairs from fetch for decode.
// Ports: clk, rst, flush, in_valid/in_pc/in_instr/in_ready (fetch side),
// out_valid/out_pc/out_instr/out_ready (decode side), count (occupancy).
module if_id_queue
  import if_pkg::*;
#(
  parameter int DEPTH  = IF_Q_DEPTH,
  parameter int DATA_W = IF_DATA_W,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_instr,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);

  // flush wins: anything fetched in a flush cycle is wrong-path
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  if_queue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (wr_ptr)
  );

  if_queue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (flush)
      count <= '0;
    else if (push && !pop)
      count <= count + CNT_W'(1);
    else if (pop && !push)
      count <= count - CNT_W'(1);
  end

  // stale entries stay in storage after a flush; masking hides them
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue.
// Scoreboard queue models FIFO contents; tasks check per scenario.
module tb_if_id_queue;
  import if_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_pc;
  logic [DW-1:0] in_instr;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_pc;
  logic [DW-1:0] out_instr;
  logic          out_ready;
  logic [CW-1:0] count;

  if_entry_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  if_id_queue #(.DEPTH(DEPTH), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  // {out_valid, in_ready, count, out_pc, out_instr} from the model
  function automatic logic [2*DW+CW+1:0] exp_vec();
    logic [DW-1:0] p, i;
    p = '0;
    i = '0;
    if (exp_q.size() > 0) begin
      p = exp_q[0].pc;
      i = exp_q[0].instr;
    end
    return {exp_q.size() > 0, exp_q.size() < DEPTH,
            CW'(exp_q.size()), p, i};
  endfunction

  function automatic logic [2*DW+CW+1:0] obs_vec();
    return {out_valid, in_ready, count, out_pc, out_instr};
  endfunction

  // advance one edge, updating the scoreboard from the driven inputs
  task automatic tick();
    logic do_push, do_pop;
    do_push = in_valid && (exp_q.size() < DEPTH) && !flush;
    do_pop  = out_ready && (exp_q.size() > 0) && !flush;
    @(posedge clk);
    if (flush) exp_q.delete();
    else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back('{pc: in_pc, instr: in_instr});
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; out_ready = 0;
    in_pc = '0; in_instr = '0;
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = 1;
    for (int k = 0; k <= DEPTH && exp_q.size() > 0; k++) tick();
    out_ready = 0;
    n_cmp++;
    if (count !== '0) begin
      n_bad++;
      $display("FAIL drain: count=%0d required 0", count);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #1;
    n_cmp++;
    if (obs_vec() !== {1'b0, 1'b1, CW'(0), 64'h0}) begin
      n_bad++;
      $display("FAIL reset_hold: got %h required %h",
               obs_vec(), {1'b0, 1'b1, CW'(0), 64'h0});
    end
    @(posedge clk); #1;
    rst = 0;
    tick(); tick();
    n_cmp++;
    if (obs_vec() !== {1'b0, 1'b1, CW'(0), 64'h0}) begin
      n_bad++;
      $display("FAIL reset_idle: got %h", obs_vec());
    end
  endtask

  task automatic test_push_one();
    idle_inputs();
    in_valid = 1; in_pc = 32'd4; in_instr = 32'hE3A00001;
    tick();
    idle_inputs();
    n_cmp++;
    if ({out_valid, out_pc, out_instr, count} !==
        {1'b1, 32'd4, 32'hE3A00001, CW'(1)}) begin
      n_bad++;
      $display("FAIL push_one: v=%b pc=%h ins=%h cnt=%0d req 1/4/e3a00001/1",
               out_valid, out_pc, out_instr, count);
    end
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL push_one_sb: got %h required %h", obs_vec(), exp_vec());
    end
    drain();
  endtask

  task automatic test_full();
    logic [DW-1:0] want [4];
    want = '{32'd4, 32'd8, 32'd12, 32'd16};
    idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1; in_pc = 32'(4 * k); in_instr = 32'h1000 + 32'(k);
      tick();
    end
    n_cmp++;
    if (in_ready !== 1'b0 || count !== CW'(4)) begin
      n_bad++;
      $display("FAIL full_flag: in_ready=%b cnt=%0d required 0/4",
               in_ready, count);
    end
    in_pc = 32'd20; in_instr = 32'h2000;
    tick();
    n_cmp++;
    if (obs_vec() !== exp_vec() || count !== CW'(4)) begin
      n_bad++;
      $display("FAIL full_refuse: got %h required %h", obs_vec(), exp_vec());
    end
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (out_pc !== want[k] || obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL full_pop%0d: pc=%h required %h", k, out_pc, want[k]);
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b0 || count !== '0) begin
      n_bad++;
      $display("FAIL full_empty: v=%b cnt=%0d required 0/0",
               out_valid, count);
    end
    tick();
    n_cmp++;
    if (count !== '0) begin
      n_bad++;
      $display("FAIL underflow: cnt=%0d required 0", count);
    end
    idle_inputs();
  endtask

  task automatic test_full_pop_push();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_pc = 32'h40 + 32'(4 * k); in_instr = 32'(k);
      tick();
    end
    in_pc = 32'h80; out_ready = 1;
    tick();
    n_cmp++;
    if (count !== CW'(3) || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL full_pop_push: cnt=%0d required 3 (%h vs %h)",
               count, obs_vec(), exp_vec());
    end
    drain();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    in_valid = 1; out_ready = 1;
    for (int k = 1; k <= 10; k++) begin
      in_pc = 32'(4 * k); in_instr = 32'h13000000 | 32'(k);
      tick();
      n_cmp++;
      if (count !== CW'(1) || out_pc !== 32'(4 * k) ||
          obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL b2b%0d: cnt=%0d pc=%h required 1/%h",
                 k, count, out_pc, 32'(4 * k));
      end
    end
    drain();
  endtask

  task automatic test_flush();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_pc = 32'h10 + 32'(4 * k); in_instr = 32'hAA00 + 32'(k);
      tick();
    end
    flush = 1; in_valid = 1; in_pc = 32'h100; in_instr = 32'hBEEF;
    out_ready = 1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_ready: in_ready=%b required 1", in_ready);
    end
    tick();
    idle_inputs();
    n_cmp++;
    if ({out_valid, count, out_pc, out_instr} !== {1'b0, CW'(0), 64'h0}) begin
      n_bad++;
      $display("FAIL flush_empty: v=%b cnt=%0d pc=%h", out_valid, count, out_pc);
    end
    in_valid = 1; in_pc = 32'h104; in_instr = 32'hC0DE;
    tick();
    idle_inputs();
    n_cmp++;
    if (out_pc !== 32'h104 || count !== CW'(1) || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL flush_next: pc=%h cnt=%0d required 104/1", out_pc, count);
    end
    drain();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; in_pc = 32'h200 + 32'(4 * k); in_instr = 32'(k + 7);
      tick();
    end
    idle_inputs();
    #2 rst = 1;
    #1;
    n_cmp++;
    if (count !== '0 || out_valid !== 1'b0 || out_pc !== '0) begin
      n_bad++;
      $display("FAIL async_rst: cnt=%0d v=%b pc=%h required 0/0/0",
               count, out_valid, out_pc);
    end
    exp_q.delete();
    #1 rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    idle_inputs();
    for (int k = 0; k < 300; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_pc     = $urandom;
      in_instr  = $urandom;
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random%0d: got %h required %h", k, obs_vec(), exp_vec());
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_push_one();
    test_full();
    test_full_pop_push();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
